// File: rtl/sensor_pkg.sv
// Shared types and constants for the image sensor model and its capture stage.
// Optional build macro: LUMA_ROUND_EN (round-to-nearest luma instead of truncation).
package sensor_pkg;

   // Line-state encoding used by the upstream sensor model
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VSYNC = 2'd1,
      ST_HSYNC = 2'd2,
      ST_DATA  = 2'd3
   } sensor_state_t;

   // Capture-side frame tracking state
   typedef enum logic [1:0] {
      CAP_WAIT_FRAME = 2'd0,
      CAP_CAPTURE    = 2'd1,
      CAP_FRAME_END  = 2'd2
   } cap_state_t;

   // BT.601-style integer luma weights (sum = 256) and rounding bias
   localparam logic [15:0] LUMA_COEF_R = 16'd77;
   localparam logic [15:0] LUMA_COEF_G = 16'd150;
   localparam logic [15:0] LUMA_COEF_B = 16'd29;
   localparam logic [15:0] LUMA_BIAS   = 16'd128;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pair_tags_t;

   // One FIFO entry: tags on top, {luma1, luma0} below
   typedef struct packed {
      pair_tags_t tags;
      logic [7:0] luma1;
      logic [7:0] luma0;
   } fifo_word_t;

   localparam int FIFO_W = $bits(fifo_word_t);

   // Sum of pre-weighted channels scaled back to 8 bits; never exceeds 16 bits
   function automatic logic [7:0] luma_of(input logic [15:0] pr,
                                          input logic [15:0] pg,
                                          input logic [15:0] pb);
      logic [15:0] sum;
`ifdef LUMA_ROUND_EN
      sum = pr + pg + pb + LUMA_BIAS;
`else
      sum = pr + pg + pb;
`endif
      return 8'(sum >> 8);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and combinational (fall-through) head.
// Push at full succeeds only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   output logic                     push_ok,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          full;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign push_ok = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // Storage array: written on accepted push
   // NOTE: the memory has no reset -- the pointers and count define what is valid,
   // so clearing the array would only cost flops and reset fan-out.
   always_ff @(posedge HCLK) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gray_pair_capture.sv
// Captures RGB pixel pairs from the sensor, converts them to 8-bit luma, tags
// frame/line boundaries and buffers packed pairs for the frame writer.
// Optional build macro: LUMA_ROUND_EN (see sensor_pkg::luma_of).
module gray_pair_capture
   import sensor_pkg::*;
#(
   parameter int WIDTH      = 240,
   parameter int HEIGHT     = 320,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          VSYNC,
   input  logic                          HSYNC,
   input  logic                          pix_valid,
   input  logic [7:0]                    DATA_R0,
   input  logic [7:0]                    DATA_G0,
   input  logic [7:0]                    DATA_B0,
   input  logic [7:0]                    DATA_R1,
   input  logic [7:0]                    DATA_G1,
   input  logic [7:0]                    DATA_B1,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [15:0]                   out_data,
   output logic                          out_sof,
   output logic                          out_eol,
   output logic                          out_eof,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_done,
   output logic                          err_ovf,
   output logic                          err_len,
   output logic                          err_short
);

   localparam int PAIRS = WIDTH / 2;
   localparam int CW    = (PAIRS > 1)  ? $clog2(PAIRS)  : 1;
   localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   cap_state_t    state;
   logic          vsync_q;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic          vsync_rise;
   logic          pair_in;
   logic          take;
   logic          last_col;
   logic          last_row;

   // Line strobe is informational only
   logic          unused_hsync;
   assign unused_hsync = HSYNC;

   assign vsync_rise = VSYNC & ~vsync_q;
   assign pair_in    = pix_valid & ~VSYNC;
   assign take       = pair_in & (state == CAP_CAPTURE);
   assign last_col   = (col == CW'(PAIRS - 1));
   assign last_row   = (row == RW'(HEIGHT - 1));

   // Frame tracking: state, position counters, length/short faults
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= CAP_WAIT_FRAME;
         vsync_q   <= 1'b0;
         col       <= '0;
         row       <= '0;
         err_len   <= 1'b0;
         err_short <= 1'b0;
      end else begin
         vsync_q <= VSYNC;
         if (vsync_rise) begin
            if (state == CAP_CAPTURE && (row != '0 || col != '0)) err_short <= 1'b1;
            state <= CAP_CAPTURE;
            col   <= '0;
            row   <= '0;
         end else if (take) begin
            if (last_col) begin
               col <= '0;
               if (last_row) begin
                  row   <= '0;
                  state <= CAP_FRAME_END;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end else if (pair_in) begin
            err_len <= 1'b1;
         end
      end
   end

   // Pipeline valid bits and tags
   logic       s1_valid;
   pair_tags_t s1_tags;
   logic       s2_valid;
   pair_tags_t s2_tags;
   logic       fifo_push_ok;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s1_valid   <= 1'b0;
         s1_tags    <= '0;
         s2_valid   <= 1'b0;
         s2_tags    <= '0;
         frame_done <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         s1_valid     <= take;
         s1_tags.sof  <= (row == '0) && (col == '0);
         s1_tags.eol  <= last_col;
         s1_tags.eof  <= last_col && last_row;
         s2_valid     <= s1_valid;
         s2_tags      <= s1_tags;
         frame_done   <= s2_valid & s2_tags.eof;
         if (s2_valid && !fifo_push_ok) err_ovf <= 1'b1;
      end
   end

   // Datapath: weighted products at E0, luma at E1 (qualified by valid bits)
   logic [15:0] s1_p [6];
   logic [7:0]  s2_luma0;
   logic [7:0]  s2_luma1;

   always_ff @(posedge HCLK) begin
      s1_p[0]  <= 16'(DATA_R0) * LUMA_COEF_R;
      s1_p[1]  <= 16'(DATA_G0) * LUMA_COEF_G;
      s1_p[2]  <= 16'(DATA_B0) * LUMA_COEF_B;
      s1_p[3]  <= 16'(DATA_R1) * LUMA_COEF_R;
      s1_p[4]  <= 16'(DATA_G1) * LUMA_COEF_G;
      s1_p[5]  <= 16'(DATA_B1) * LUMA_COEF_B;
      s2_luma0 <= luma_of(s1_p[0], s1_p[1], s1_p[2]);
      s2_luma1 <= luma_of(s1_p[3], s1_p[4], s1_p[5]);
   end

   fifo_word_t wr_word;
   fifo_word_t head;
   fifo_word_t out_word;
   logic       fifo_empty;

   assign wr_word = '{tags: s2_tags, luma1: s2_luma1, luma0: s2_luma0};

   sync_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .push    (s2_valid),
      .wdata   (wr_word),
      .push_ok (fifo_push_ok),
      .pop     (out_valid & out_ready),
      .rdata   (head),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Head is masked while empty so outputs read zero after reset
   assign out_valid = ~fifo_empty;
   assign out_word  = out_valid ? head : '0;
   assign out_data  = {out_word.luma1, out_word.luma0};
   assign out_sof   = out_word.tags.sof;
   assign out_eol   = out_word.tags.eol;
   assign out_eof   = out_word.tags.eof;

endmodule

// File: tb/tb_gray_pair_capture.sv
// Directed, table-driven bench for gray_pair_capture (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4).
module tb_gray_pair_capture;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        VSYNC, HSYNC, pix_valid, out_ready;
   logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
   logic        out_valid, out_sof, out_eol, out_eof;
   logic [15:0] out_data;
   logic [2:0]  fifo_level;
   logic        frame_done, err_ovf, err_len, err_short;

   gray_pair_capture #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
      .pix_valid(pix_valid),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
      .fifo_level(fifo_level), .frame_done(frame_done),
      .err_ovf(err_ovf), .err_len(err_len), .err_short(err_short)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [7:0]  r0, g0, b0, r1, g1, b1;
      logic [15:0] exp_data;
      logic [2:0]  exp_tags;   // {sof, eol, eof}
   } vec_t;

   vec_t        vecs [4];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          last_e0 = 0;
   int          fd_count = 0;
   int          fd_cyc   = 0;
   logic [18:0] cap [$];

   always @(posedge HCLK) cyc++;

   // Record every accepted word and frame_done pulses, mid-cycle
   always @(negedge HCLK) begin
      if (out_valid && out_ready) cap.push_back({out_sof, out_eol, out_eof, out_data});
      if (frame_done) begin
         fd_count++;
         fd_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      pix_valid = 1'b0;
      repeat (n) begin
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic pair(input logic [7:0] r0, g0, b0, r1, g1, b1);
      pix_valid = 1'b1;
      DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
      DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
      last_e0 = cyc + 1;
      @(posedge HCLK);
      #1;
   endtask

   task automatic vsync_pulse();
      pix_valid = 1'b0;
      VSYNC = 1'b1;
      @(posedge HCLK);
      #1;
      VSYNC = 1'b0;
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      pix_valid = 1'b0;
      VSYNC = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      idle(1);
      cap.delete();
   endtask

   task automatic check_cap(input string name, input int i, input logic [18:0] exp);
      if (i < cap.size()) check(name, 32'(cap[i]), 32'(exp));
      else check({name, " missing"}, 32'(cap.size()), 32'(i + 1));
   endtask

   initial begin
      // {r0,g0,b0, r1,g1,b1, {luma1,luma0}, {sof,eol,eof}}
`ifdef LUMA_ROUND_EN
      vecs[0] = '{8'd2,   8'd0,   8'd0,  8'd0,   8'd0,   8'd255, 16'h1D01, 3'b100};
      vecs[1] = '{8'd100, 8'd0,   8'd0,  8'd0,   8'd100, 8'd0,   16'h3B1E, 3'b010};
      vecs[2] = '{8'd10,  8'd20,  8'd30, 8'd200, 8'd100, 8'd50,  16'h7C12, 3'b000};
      vecs[3] = '{8'd0,   8'd255, 8'd0,  8'd255, 8'd0,   8'd0,   16'h4D95, 3'b011};
`else
      vecs[0] = '{8'd2,   8'd0,   8'd0,  8'd0,   8'd0,   8'd255, 16'h1C00, 3'b100};
      vecs[1] = '{8'd100, 8'd0,   8'd0,  8'd0,   8'd100, 8'd0,   16'h3A1E, 3'b010};
      vecs[2] = '{8'd10,  8'd20,  8'd30, 8'd200, 8'd100, 8'd50,  16'h7C12, 3'b000};
      vecs[3] = '{8'd0,   8'd255, 8'd0,  8'd255, 8'd0,   8'd0,   16'h4C95, 3'b011};
`endif

      HRESETn = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
      DATA_R0 = '0; DATA_G0 = '0; DATA_B0 = '0; DATA_R1 = '0; DATA_G1 = '0; DATA_B1 = '0;
      @(posedge HCLK);
      #1;
      check("reset out_valid",  32'(out_valid), 0);
      check("reset out_data",   32'(out_data), 0);
      check("reset tags",       32'({out_sof, out_eol, out_eof}), 0);
      check("reset fifo_level", 32'(fifo_level), 0);
      check("reset frame_done", 32'(frame_done), 0);
      check("reset errors",     32'({err_ovf, err_len, err_short}), 0);
      HRESETn = 1'b1;
      idle(1);

      // Frame of white/black pairs, consumer always ready
      out_ready = 1'b1;
      fd_count = 0;
      vsync_pulse();
      repeat (4) pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      idle(6);
      check("white size", 32'(cap.size()), 4);
      check_cap("white w0", 0, {3'b100, 16'h00FF});
      check_cap("white w1", 1, {3'b010, 16'h00FF});
      check_cap("white w2", 2, {3'b000, 16'h00FF});
      check_cap("white w3", 3, {3'b011, 16'h00FF});
      check("frame_done count", 32'(fd_count), 1);
      check("frame_done cycle", 32'(fd_cyc), 32'(last_e0 + 2));
      check("white errors", 32'({err_ovf, err_len, err_short}), 0);

      // Table frame: luma arithmetic and tags
      cap.delete();
      vsync_pulse();
      for (int i = 0; i < 4; i++)
         pair(vecs[i].r0, vecs[i].g0, vecs[i].b0, vecs[i].r1, vecs[i].g1, vecs[i].b1);
      idle(6);
      check("table size", 32'(cap.size()), 4);
      for (int i = 0; i < 4; i++)
         check_cap($sformatf("table w%0d", i), i, {vecs[i].exp_tags, vecs[i].exp_data});
      check("table err_short", 32'(err_short), 0);

      // Overflow: six pairs into a 4-deep FIFO with the consumer stalled
      do_reset();
      out_ready = 1'b0;
      vsync_pulse();
      for (int i = 0; i < 4; i++)
         pair(vecs[i].r0, vecs[i].g0, vecs[i].b0, vecs[i].r1, vecs[i].g1, vecs[i].b1);
      vsync_pulse();
      repeat (2) pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      idle(5);
      check("ovf level",     32'(fifo_level), 4);
      check("ovf err_ovf",   32'(err_ovf), 1);
      check("ovf head hold", 32'({out_valid, out_sof, out_data}), 32'({2'b11, vecs[0].exp_data}));
      out_ready = 1'b1;
      idle(8);
      check("ovf drained size", 32'(cap.size()), 4);
      for (int i = 0; i < 4; i++)
         check_cap($sformatf("ovf w%0d", i), i, {vecs[i].exp_tags, vecs[i].exp_data});
      check("ovf sticky", 32'(err_ovf), 1);

      // Short frame: VSYNC after three pairs
      do_reset();
      out_ready = 1'b1;
      vsync_pulse();
      repeat (3) pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      vsync_pulse();
      pair(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255);
      idle(6);
      check("short err_short", 32'(err_short), 1);
      check("short err_len",   32'(err_len), 0);
      check("short size",      32'(cap.size()), 4);
      check_cap("short new sof", 3, {3'b100, vecs[0].exp_data});

      // Pairs before any VSYNC are dropped
      do_reset();
      pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      idle(6);
      check("early err_len", 32'(err_len), 1);
      check("early size",    32'(cap.size()), 0);

      // A fifth pair in a four-pair frame is dropped
      do_reset();
      vsync_pulse();
      repeat (5) pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      idle(6);
      check("long err_len", 32'(err_len), 1);
      check("long size",    32'(cap.size()), 4);
      check("long err_ovf", 32'(err_ovf), 0);

      // Asynchronous reset with three words buffered and a fault flagged
      do_reset();
      out_ready = 1'b0;
      vsync_pulse();
      repeat (3) pair(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      idle(4);
      vsync_pulse();
      check("pre-reset level",     32'(fifo_level), 3);
      check("pre-reset err_short", 32'(err_short), 1);
      HRESETn = 1'b0;
      #2;
      check("async reset out_valid", 32'(out_valid), 0);
      check("async reset level",     32'(fifo_level), 0);
      check("async reset errors",    32'({err_ovf, err_len, err_short}), 0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
